serial_adder: RTL and testbench

//  Bit-serial multi-bit adder built around one 1-bit full-adder stage
//  (A, B, Cin -> Sum, Cout) plus a carry flip-flop.

---
 rtl/serial_adder_if.sv | 25 ++
 rtl/serial_adder.sv | 103 ++++++++++
 tb/tb_serial_adder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder: operands and start in,
// handshake status plus result word out.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;

  modport master (
    output start, A, B, Cin,
    input  ready, busy, done, Sum, Cout
  );

  modport slave (
    input  start, A, B, Cin,
    output ready, busy, done, Sum, Cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first,
// WIDTH cycles per addition, result collected by shifting in at the MSB.
//
// state  | meaning
// S_IDLE | waiting for start; ready=1
// S_RUN  | one operand bit pair added per clock; busy=1
// S_DONE | Sum/Cout final; done=1 for this single cycle
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  serial_adder_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic             cout_r;
  logic [CW-1:0]    cnt;
  logic             ready_r;
  logic             busy_r;
  logic             done_r;

  logic fa_sum;
  logic fa_cout;

  assign fa_sum  = a_sr[0] ^ b_sr[0] ^ carry;
  assign fa_cout = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

  // Status flags are registered alongside the state so no path exists from start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      sum_r   <= '0;
      carry   <= 1'b0;
      cout_r  <= 1'b0;
      cnt     <= '0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_sr    <= bus.A;
            b_sr    <= bus.B;
            carry   <= bus.Cin;
            cnt     <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            state   <= S_RUN;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        S_RUN: begin
          sum_r <= {fa_sum, sum_r[WIDTH-1:1]};
          carry <= fa_cout;
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            cout_r <= fa_cout;
            state  <= S_DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          done_r  <= 1'b0;
          ready_r <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = ready_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.Sum   = sum_r;
  assign bus.Cout  = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed and random 8-bit additions plus an
// exhaustive 4-bit sweep, all checked against plain A+B+Cin arithmetic.
module tb_serial_adder;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(4)) bus4 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts one 8-bit addition in the current (ready) cycle and waits for done.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      output logic [7:0] s, output logic co, output int lat, output int busy_n);
    bus8.A = a;
    bus8.B = b;
    bus8.Cin = c;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    lat = 0;
    busy_n = 0;
    while (bus8.done !== 1'b1 && lat < 40) begin
      if (bus8.busy === 1'b1) busy_n++;
      tick();
      lat++;
    end
    s  = bus8.Sum;
    co = bus8.Cout;
  endtask

  logic [7:0] s8;
  logic       co8;
  int         lat;
  int         busy_n;
  logic [8:0] exp9;

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    bus8.start = 1'b0; bus8.A = '0; bus8.B = '0; bus8.Cin = 1'b0;
    bus4.start = 1'b0; bus4.A = '0; bus4.B = '0; bus4.Cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("reset_ready", 64'(bus8.ready), 64'd1);
    check("reset_busy",  64'(bus8.busy),  64'd0);
    check("reset_done",  64'(bus8.done),  64'd0);
    check("reset_sum",   64'(bus8.Sum),   64'd0);
    check("reset_cout",  64'(bus8.Cout),  64'd0);

    // Zero operands, with latency and busy-length checks
    run8(8'h00, 8'h00, 1'b0, s8, co8, lat, busy_n);
    check("t1_done_seen", 64'(bus8.done), 64'd1);
    check("t1_latency",   64'(lat),       64'd8);
    check("t1_busy_len",  64'(busy_n),    64'd8);
    check("t1_sum",  64'(s8),  64'h00);
    check("t1_cout", 64'(co8), 64'd0);
    tick();
    check("t1_done_one_cycle", 64'(bus8.done),  64'd0);
    check("t1_ready_after",    64'(bus8.ready), 64'd1);

    run8(8'hFF, 8'h01, 1'b0, s8, co8, lat, busy_n);
    check("t2_sum",  64'(s8),  64'h00);
    check("t2_cout", 64'(co8), 64'd1);
    tick();

    run8(8'hA5, 8'h5A, 1'b1, s8, co8, lat, busy_n);
    check("t3a_sum",  64'(s8),  64'h00);
    check("t3a_cout", 64'(co8), 64'd1);
    tick();
    run8(8'h3C, 8'h42, 1'b0, s8, co8, lat, busy_n);
    check("t3b_sum",  64'(s8),  64'h7E);
    check("t3b_cout", 64'(co8), 64'd0);
    tick();

    // start pulses during RUN and DONE must be ignored
    bus8.A = 8'h10; bus8.B = 8'h20; bus8.Cin = 1'b0; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick();
    bus8.A = 8'hFF; bus8.start = 1'b1;
    check("t4_sum_zero_in_run", 64'(bus8.Sum), 64'd0);
    tick();
    bus8.start = 1'b0;
    lat = 0;
    busy_n = 0;
    while (bus8.done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check("t4_done_seen", 64'(bus8.done), 64'd1);
    check("t4_sum",  64'(bus8.Sum),  64'h30);
    check("t4_cout", 64'(bus8.Cout), 64'd0);
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    check("t4_ready_after_done", 64'(bus8.ready), 64'd1);
    tick();
    for (int i = 0; i < 12; i++) begin
      if (bus8.done === 1'b1 || bus8.busy === 1'b1) busy_n++;
      tick();
    end
    check("t4_no_second_run", 64'(busy_n), 64'd0);
    check("t4_sum_held", 64'(bus8.Sum), 64'h30);

    // Reset during the 4th RUN cycle aborts the addition
    bus8.A = 8'h77; bus8.B = 8'h99; bus8.Cin = 1'b1; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick();
    tick();
    tick();
    check("t5_busy_before_rst", 64'(bus8.busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_ready", 64'(bus8.ready), 64'd1);
    check("t5_sum",   64'(bus8.Sum),   64'd0);
    check("t5_cout",  64'(bus8.Cout),  64'd0);
    busy_n = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus8.done === 1'b1) busy_n++;
      tick();
    end
    check("t5_no_done", 64'(busy_n), 64'd0);
    run8(8'h01, 8'h01, 1'b1, s8, co8, lat, busy_n);
    check("t5_sum_after", 64'(s8),  64'h03);
    check("t5_cout_after", 64'(co8), 64'd0);
    tick();

    // Random operands against plain arithmetic
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      exp9 = 9'(ra) + 9'(rb) + 9'(rc);
      run8(ra, rb, rc, s8, co8, lat, busy_n);
      check("rand_latency", 64'(lat), 64'd8);
      check("rand_result", 64'({co8, s8}), 64'(exp9));
      tick();
    end

    // Exhaustive 4-bit sweep, back-to-back, with one-hot status each cycle
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          logic [4:0] exp5;
          int         wait_n;
          exp5 = 5'(a) + 5'(b) + 5'(c);
          check("w4_ready_at_start", 64'(bus4.ready), 64'd1);
          bus4.A = 4'(a);
          bus4.B = 4'(b);
          bus4.Cin = 1'(c);
          bus4.start = 1'b1;
          tick();
          bus4.start = 1'b0;
          wait_n = 0;
          while (bus4.done !== 1'b1 && wait_n < 20) begin
            check("w4_onehot", 64'($countones({bus4.ready, bus4.busy, bus4.done})), 64'd1);
            tick();
            wait_n++;
          end
          check("w4_latency", 64'(wait_n), 64'd4);
          check("w4_onehot_done", 64'($countones({bus4.ready, bus4.busy, bus4.done})), 64'd1);
          check("w4_result", 64'({bus4.Cout, bus4.Sum}), 64'(exp5));
          tick();
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
